// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute stage.
// Op codes match the ALU controller's aluControl output.
package alu_exec_unit_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_BCMP  = 4'b1001;
    localparam logic [3:0] ALU_BEQ   = 4'b1010;
    localparam logic [3:0] ALU_UPIMM = 4'b1011;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_kind_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: moves up to SHIFT_PER_CYCLE bits per cycle.
// done is high in the cycle whose step finishes the shift.
module alu_iter_shifter
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    start,
    input  shift_kind_t             kind,
    input  logic [XLEN-1:0]         operand,
    input  logic [$clog2(XLEN)-1:0] shamt,
    output logic                    done,
    output logic [XLEN-1:0]         value
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] SPC_W = CW'(SHIFT_PER_CYCLE);

    logic [XLEN-1:0] data_q;
    logic [CW-1:0]   rem_q;
    shift_kind_t     kind_q;
    logic [CW-1:0]   step;
    logic [XLEN-1:0] shifted;

    assign step = (rem_q < SPC_W) ? rem_q : SPC_W;

    always_comb begin
        shifted = data_q;
        case (kind_q)
            SH_SLL:  shifted = data_q << step;
            SH_SRL:  shifted = data_q >> step;
            SH_SRA:  shifted = $unsigned($signed(data_q) >>> step);
            default: shifted = data_q;
        endcase
    end

    assign done  = (rem_q != '0) && (rem_q <= SPC_W);
    assign value = shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            rem_q  <= '0;
            kind_q <= SH_SLL;
        end else if (flush) begin
            rem_q <= '0;
        end else if (start) begin
            data_q <= operand;
            rem_q  <= {1'b0, shamt};
            kind_q <= kind;
        end else if (rem_q != '0) begin
            data_q <= shifted;
            rem_q  <= rem_q - step;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops, iterative shifts,
// one registered result with valid/ready stall hold.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [3:0]      aluControl,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            ltSigned,
    output logic            ltUnsigned,
    output logic            illegalOp
);

    localparam int SW = $clog2(XLEN);

    state_t          state_q;
    state_t          state_d;
    logic [SW-1:0]   shamt;
    logic            accept;
    logic            long_shift;
    logic            lts_c;
    logic            ltu_c;
    logic            illegal_c;
    logic [XLEN-1:0] alu_res;
    shift_kind_t     kind;
    logic            sh_done;
    logic [XLEN-1:0] sh_value;
    logic            pend_lts;
    logic            pend_ltu;

    assign shamt      = operandB[SW-1:0];
    assign long_shift = is_shift(aluControl) && (shamt != '0);
    assign inReady    = !flush && (state_q == IDLE)
                        && (!outValid || outReady);
    assign accept     = inValid && inReady;
    assign lts_c      = $signed(operandA) < $signed(operandB);
    assign ltu_c      = operandA < operandB;
    assign illegal_c  = (aluControl[3:2] == 2'b11);

    always_comb begin
        kind = SH_SLL;
        if (aluControl == ALU_SRL) kind = SH_SRL;
        if (aluControl == ALU_SRA) kind = SH_SRA;
    end

    // Shift ops reaching here have shamt==0, so they pass A.
    always_comb begin
        alu_res = '0;
        case (aluControl)
            ALU_ADD:   alu_res = operandA + operandB;
            ALU_SUB,
            ALU_BCMP,
            ALU_BEQ:   alu_res = operandA - operandB;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   alu_res = operandA;
            ALU_XOR:   alu_res = operandA ^ operandB;
            ALU_OR:    alu_res = operandA | operandB;
            ALU_AND:   alu_res = operandA & operandB;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ltu_c};
            ALU_UPIMM: alu_res = operandB;
            default:   alu_res = '0;
        endcase
    end

    alu_iter_shifter #(
        .XLEN            (XLEN),
        .SHIFT_PER_CYCLE (SHIFT_PER_CYCLE)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .start   (accept && long_shift),
        .kind    (kind),
        .operand (operandA),
        .shamt   (shamt),
        .done    (sh_done),
        .value   (sh_value)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (accept && long_shift) state_d = SHIFT;
                SHIFT: if (sh_done) state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Flags for a shift are parked until the shift completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid   <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            ltSigned   <= 1'b0;
            ltUnsigned <= 1'b0;
            illegalOp  <= 1'b0;
            pend_lts   <= 1'b0;
            pend_ltu   <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (sh_done) begin
                outValid   <= 1'b1;
                result     <= sh_value;
                zero       <= (sh_value == '0);
                ltSigned   <= pend_lts;
                ltUnsigned <= pend_ltu;
                illegalOp  <= 1'b0;
            end
        end else if (accept) begin
            if (long_shift) begin
                outValid <= 1'b0;
                pend_lts <= lts_c;
                pend_ltu <= ltu_c;
            end else begin
                outValid   <= 1'b1;
                result     <= alu_res;
                zero       <= (alu_res == '0);
                ltSigned   <= lts_c;
                ltUnsigned <= ltu_c;
                illegalOp  <= illegal_c;
            end
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, one bit per shift step).
// Each task checks its own scenario against hand-computed values.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [3:0]  aluControl = 4'b0;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        ltSigned;
    logic        ltUnsigned;
    logic        illegalOp;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(.XLEN(32), .SHIFT_PER_CYCLE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .aluControl (aluControl),
        .operandA   (operandA),
        .operandB   (operandB),
        .outValid   (outValid),
        .outReady   (outReady),
        .result     (result),
        .zero       (zero),
        .ltSigned   (ltSigned),
        .ltUnsigned (ltUnsigned),
        .illegalOp  (illegalOp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        n_checks++;
        if ({outValid, zero, ltSigned, ltUnsigned, illegalOp} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000",
                     {outValid, zero, ltSigned, ltUnsigned, illegalOp});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result got %h want 0", result);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_inready got %b want 1", inReady);
        end
    endtask

    task automatic test_add();
        aluControl = 4'b0000;
        operandA = 32'h7FFF_FFFF;
        operandB = 32'h0000_0001;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        n_checks++;
        if (outValid !== 1'b1 || result !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL add_result got v=%b %h want v=1 80000000",
                     outValid, result);
        end
        n_checks++;
        if ({zero, ltSigned, ltUnsigned} !== 3'b000) begin
            n_fail++;
            $display("FAIL add_flags got %b want 000",
                     {zero, ltSigned, ltUnsigned});
        end
        step();
        n_checks++;
        if (outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_consumed got %b want 0", outValid);
        end
    endtask

    task automatic test_ops();
        logic [3:0]  ops [8] = '{4'b0001, 4'b0011, 4'b0110, 4'b0111,
                                 4'b1011, 4'b1001, 4'b1000, 4'b1000};
        logic [31:0] as [8] = '{32'h0, 32'hF0F0F0F0, 32'h0F0F0000,
                                32'hF0F0F0F0, 32'h12345000, 32'h5,
                                32'h7, 32'hFFFFFFFF};
        logic [31:0] bs [8] = '{32'h1, 32'hFF00FF00, 32'h000000F0,
                                32'hFF00FF00, 32'hABCD0000, 32'h7,
                                32'h3, 32'h1};
        logic [31:0] ex [8] = '{32'hFFFFFFFF, 32'h0FF00FF0, 32'h0F0F00F0,
                                32'hF000F000, 32'hABCD0000, 32'hFFFFFFFE,
                                32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            aluControl = ops[i];
            operandA = as[i];
            operandB = bs[i];
            inValid = 1'b1;
            step();
            n_checks++;
            if (outValid !== 1'b1 || result !== ex[i]) begin
                n_fail++;
                $display("FAIL ops[%0d] got v=%b %h want v=1 %h",
                         i, outValid, result, ex[i]);
            end
        end
        inValid = 1'b0;
        n_checks++;
        if ({ltSigned, ltUnsigned} !== 2'b10) begin
            n_fail++;
            $display("FAIL ops_slt_flags got %b want 10",
                     {ltSigned, ltUnsigned});
        end
        step();
    endtask

    task automatic test_sra();
        int cyc;
        int low_ready;
        aluControl = 4'b0101;
        operandA = 32'h8000_0000;
        operandB = 32'h4;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        cyc = 1;
        low_ready = 0;
        while (outValid !== 1'b1 && cyc < 20) begin
            if (inReady === 1'b0) low_ready++;
            step();
            cyc++;
        end
        n_checks++;
        if (cyc !== 5 || low_ready !== 4) begin
            n_fail++;
            $display("FAIL sra_latency got T+%0d low=%0d want T+5 low=4",
                     cyc, low_ready);
        end
        n_checks++;
        if (outValid !== 1'b1 || result !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL sra_result got v=%b %h want v=1 f8000000",
                     outValid, result);
        end
        n_checks++;
        if ({zero, ltSigned, ltUnsigned} !== 3'b010) begin
            n_fail++;
            $display("FAIL sra_flags got %b want 010",
                     {zero, ltSigned, ltUnsigned});
        end
        step();
    endtask

    task automatic test_back_to_back();
        aluControl = 4'b1010;
        operandA = 32'h1234;
        operandB = 32'h1234;
        inValid = 1'b1;
        step();
        n_checks++;
        if (outValid !== 1'b1 || zero !== 1'b1 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL beq got v=%b z=%b %h want v=1 z=1 0",
                     outValid, zero, result);
        end
        aluControl = 4'b1000;
        operandA = 32'h3;
        operandB = 32'h5;
        #1;
        n_checks++;
        if (inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_inready got %b want 1", inReady);
        end
        step();
        inValid = 1'b0;
        n_checks++;
        if (outValid !== 1'b1 || result !== 32'h1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL slt got v=%b z=%b %h want v=1 z=0 1",
                     outValid, zero, result);
        end
        n_checks++;
        if ({ltSigned, ltUnsigned} !== 2'b11) begin
            n_fail++;
            $display("FAIL slt_flags got %b want 11",
                     {ltSigned, ltUnsigned});
        end
        step();
    endtask

    task automatic test_stall();
        outReady = 1'b0;
        aluControl = 4'b0000;
        operandA = 32'h5;
        operandB = 32'h6;
        inValid = 1'b1;
        step();
        operandA = 32'h1;
        operandB = 32'h1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (inReady !== 1'b0 || outValid !== 1'b1
                || result !== 32'hB || ltUnsigned !== 1'b1) begin
                n_fail++;
                $display("FAIL stall[%0d] got r=%b v=%b %h u=%b want 0 1 b 1",
                         i, inReady, outValid, result, ltUnsigned);
            end
            step();
        end
        outReady = 1'b1;
        #1;
        n_checks++;
        if (inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got %b want 1", inReady);
        end
        step();
        inValid = 1'b0;
        n_checks++;
        if (outValid !== 1'b1 || result !== 32'h2 || ltUnsigned !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_new got v=%b %h u=%b want v=1 2 u=0",
                     outValid, result, ltUnsigned);
        end
        step();
    endtask

    task automatic test_flush();
        int rises;
        aluControl = 4'b0010;
        operandA = 32'h1;
        operandB = 32'd31;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        step();
        flush = 1'b1;
        #1;
        n_checks++;
        if (inReady !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_inready got %b want 0", inReady);
        end
        step();
        flush = 1'b0;
        #1;
        n_checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after got r=%b v=%b want r=1 v=0",
                     inReady, outValid);
        end
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (outValid !== 1'b0) rises++;
            step();
        end
        n_checks++;
        if (rises !== 0) begin
            n_fail++;
            $display("FAIL flush_quiet got %0d valid cycles want 0", rises);
        end
    endtask

    task automatic test_reset_mid_shift();
        int rises;
        aluControl = 4'b0000;
        operandA = 32'h5;
        operandB = 32'h6;
        inValid = 1'b1;
        step();
        aluControl = 4'b0010;
        operandA = 32'h1;
        operandB = 32'd31;
        step();
        inValid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        n_checks++;
        if (result !== 32'h0
            || {outValid, zero, ltSigned, ltUnsigned, illegalOp} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid got %h %b want 0 00000", result,
                     {outValid, zero, ltSigned, ltUnsigned, illegalOp});
        end
        step();
        reset = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (outValid !== 1'b0) rises++;
            step();
        end
        n_checks++;
        if (rises !== 0 || inReady !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_quiet got %0d valid r=%b want 0 r=1",
                     rises, inReady);
        end
    endtask

    task automatic test_illegal_and_zero_shift();
        aluControl = 4'b1110;
        operandA = 32'h5;
        operandB = 32'h7;
        inValid = 1'b1;
        step();
        n_checks++;
        if (outValid !== 1'b1 || result !== 32'h0
            || illegalOp !== 1'b1 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal got v=%b %h i=%b z=%b want 1 0 1 1",
                     outValid, result, illegalOp, zero);
        end
        aluControl = 4'b0100;
        operandA = 32'hDEAD_BEEF;
        operandB = 32'h20;
        step();
        inValid = 1'b0;
        n_checks++;
        if (outValid !== 1'b1 || result !== 32'hDEAD_BEEF
            || illegalOp !== 1'b0) begin
            n_fail++;
            $display("FAIL shamt0 got v=%b %h i=%b want 1 deadbeef 0",
                     outValid, result, illegalOp);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_sra();
        test_back_to_back();
        test_stall();
        test_illegal_and_zero_shift();
        test_flush();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the ALU controller.
- Consumes the 4-bit aluControl code plus two operands, and produces a registered result and comparison flags toward writeback/branch logic.
- Non-shift operations complete in one cycle.
- Shifts run iteratively under a small FSM to cut shifter area.
- Valid/ready handshake on both sides; single result register with stall hold.

Parameters:
- XLEN, 32, operand/result width.
- SHIFT_PER_CYCLE, 1, bit positions shifted per iteration (power of two, 1..XLEN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; drops in-flight op and any held result
- inValid  in  1  operands + aluControl valid
- inReady  out  1  unit can accept this cycle
- aluControl  in  4  op code (encoding under Behaviour)
- operandA  in  XLEN  rs1 / PC
- operandB  in  XLEN  rs2 / immediate; shift amount = operandB[$clog2(XLEN)-1:0]
- outValid  out  1  result valid
- outReady  in  1  consumer takes result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- ltSigned  out  1  $signed(A) < $signed(B), captured at accept
- ltUnsigned  out  1  A < B unsigned, captured at accept
- illegalOp  out  1  aluControl in 4'b1100..4'b1111

Behaviour:
- Encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 XOR, 0100 SRL, 0101 SRA, 0110 OR, 0111 AND.
  - 1000 SLT (unsigned compare: result = {0, A<B unsigned}).
  - 1001 branch-compare (result = A-B).
  - 1010 branch-equal (result = A-B; zero = A==B).
  - 1011 upper-immediate (result = operandB).
  - 1100-1111: result = 0, illegalOp = 1.
- Arithmetic: mod 2^XLEN, carry discarded. SRA replicates operandA[XLEN-1].
- Reset (async): state IDLE; outValid, result, zero, ltSigned, ltUnsigned, illegalOp all 0. Reset mid-shift abandons the operation.
- Handshake:
  - Accept when inValid && inReady.
  - inReady = (state==IDLE) && (!outValid || outReady).
  - Output transfer when outValid && outReady.
  - While outValid && !outReady, all outputs hold stable.
- FSM states IDLE, SHIFT:
  - IDLE, accept of non-shift op, or shift with shamt==0: result registered at next edge; outValid=1 at cycle T+1. Stay IDLE, so back-to-back ops are possible with outReady=1.
  - IDLE, accept of shift with shamt>0: latch A, remaining = shamt, kind. Go to SHIFT; outValid cleared that edge if the previous result was consumed.
  - SHIFT: each cycle shift by min(remaining, SHIFT_PER_CYCLE) and decrement remaining. When remaining reaches 0: write result, outValid=1, go to IDLE.
- Latency for shifts: 1 + ceil(shamt/SHIFT_PER_CYCLE) cycles from accept to outValid.
- Flags are computed from the original operands at accept and held with result; zero is computed on the final result.
- flush:
  - Forces IDLE and outValid=0 next edge.
  - inReady is 0 in a flush cycle (no accept).
  - Flush overrides a simultaneous accept and a simultaneous completion.
- Simultaneous outReady and accept in IDLE: old result leaves, new result loads the same edge.
- inReady is 0 throughout SHIFT; inputs are ignored.

Decomposition:
- Shared package:
  - aluControl encoding constants (ALU_ADD..ALU_UPIMM), common with the ALU controller.
  - FSM state typedef.
- Natural sub-module: alu_iter_shifter (shift register, remaining counter, done pulse).
- Combinational op select and flags live in the top.

Test Plan:
- ADD 0x7FFFFFFF + 0x1, outReady=1 -> outValid at T+1, result 0x80000000, ltSigned=0, ltUnsigned=0, zero=0.
- SRA A=0x80000000, B=4, SHIFT_PER_CYCLE=1 -> inReady low 4 cycles, outValid at T+5, result 0xF8000000.
- Branch-equal 0x1234 vs 0x1234, then SLT 3 vs 5 back-to-back, outReady=1 -> zero=1 then result=1; accept on consecutive cycles.
- ADD result with outReady=0 for 3 cycles and a new inValid -> result/flags held, inReady=0; on outReady=1 the new op is accepted the same cycle.
- SLL A=1, B=31, flush asserted mid-shift -> outValid never rises, inReady=1 next cycle. Repeat with async reset mid-shift -> all outputs 0 immediately.
- aluControl=4'b1110 -> outValid at T+1, result 0, illegalOp=1. Shift with B=0 -> T+1 latency, result = A.
